packet_collector: RTL and testbench
===================================

# packet_collector

Parametrised packet sink attached to a mesh router's local output port. It accepts packets through the req/grant/full handshake and buffers them in a DEPTH-entry FIFO. Buffered packets drain to the processing element through a valid/ready port. While receiving, it checks per-sender PacketID sequence continuity and keeps saturating receive and error counters for the simulation log.

## Interface
- ROUTER_ID, 6'b001_010: router/module identity as {x[2:0], y[2:0]}; carried for logging only.
- PACKET_W, 26: packet bus width.
- DATA_W, 9: payload field width, PacketIn[DATA_W-1:0].
- SRC_W, 6: SenderID field width, next above data.
- ID_W, 10: PacketID field width, next above SenderID.
  - Bits above DATA_W+SRC_W+ID_W are reserved and ignored.
  - Legal only if PACKET_W >= DATA_W+SRC_W+ID_W.
- DEPTH, 4: FIFO entries; a power of two, 2..64.
- CNT_W, 16: width of the statistic counters.
- SEQ_CHECK, 1: 1 enables the sequence checker; 0 ties SeqErr and ErrCount to 0.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PacketIn  in  PACKET_W  packet from the router local port.
- ReqUpStr  in  1  router requests delivery; held until granted.
- UpStrFull  out  1  registered; 1 when the FIFO holds DEPTH entries.
- GntUpStr  out  1  one-cycle grant pulse.
- PktOut  out  PACKET_W  FIFO head (show-ahead).
- PktValid  out  1  FIFO not empty.
- PktReady  in  1  PE consumes the head on a cycle with PktValid&&PktReady.
- RxCount  out  CNT_W  packets accepted; saturates at all-ones.
- ErrCount  out  CNT_W  sequence errors; saturates at all-ones.
- SeqErr  out  1  one-cycle pulse on a sequence error.
- ErrSender  out  SRC_W  SenderID of the last error; held until the next error.

## Operation
- State machine, two states.
  - WAIT_REQ: if ReqUpStr && !UpStrFull, then:
    - capture PacketIn;
    - push it into the FIFO;
    - set GntUpStr<=1;
    - go to RECEIVE_DATA.
  - WAIT_REQ with ReqUpStr && UpStrFull: stay in WAIT_REQ, GntUpStr stays 0; the request stays pending.
  - RECEIVE_DATA: GntUpStr<=0 and go to WAIT_REQ unconditionally; ReqUpStr is ignored in this state.
- FIFO behaviour:
  - Push happens only on an accepted capture.
  - Pop happens on PktValid&&PktReady.
  - Push and pop on the same edge leave the count unchanged.
  - Pop from empty is impossible because PktValid=0.
- UpStrFull is recomputed from the next count every edge, so it equals (count==DEPTH) with no lag.
- Sequence checker (SEQ_CHECK=1):
  - Table expected[0 .. 2**SRC_W-1] of ID_W bits, all 0 after reset.
  - On capture from sender s with id p: if p != expected[s], then SeqErr<=1, ErrSender<=s, and ErrCount increments.
  - In every case expected[s] <= p+1, modulo 2**ID_W, so (2**ID_W-1) followed by 0 is legal.
  - A resync after an error therefore raises only a single error.
- RxCount increments on every capture. Both counters hold at 2**CNT_W-1.

## Timing
- Reset values:
  - UpStrFull=0, GntUpStr=0, PktValid=0, SeqErr=0.
  - RxCount=0, ErrCount=0, ErrSender=0.
  - FIFO empty, state WAIT_REQ, expected table cleared.
  - PktOut is don't-care while PktValid=0.
- Capture happens at edge T, when ReqUpStr is sampled high.
  - In cycle T+1: GntUpStr=1, PktValid=1 (if the FIFO was empty), RxCount updated, SeqErr valid.
  - At T+2, GntUpStr=0.
- Throughput: at most one packet every 2 cycles.
- Router side: the router drops ReqUpStr after seeing GntUpStr. A request still high in RECEIVE_DATA is re-sampled in WAIT_REQ as a new packet; this is the router's contract.
- Full boundary:
  - At count DEPTH-1, a capture without a pop sets UpStrFull=1 from T+1.
  - A pop at count DEPTH clears UpStrFull on the next cycle.
- Capture and pop coinciding at count DEPTH cannot occur, since a capture requires !UpStrFull.
- Asynchronous reset mid-handshake drops GntUpStr immediately and discards buffered packets.

## Structure
- Shared package noc_collector_pkg holds:
  - state encodings WAIT_REQ=1'b0, RECEIVE_DATA=1'b1;
  - field-offset localparams derived from DATA_W/SRC_W/ID_W.
- Sub-module collector_fifo:
  - synchronous show-ahead FIFO, parameters WIDTH and DEPTH;
  - ports: push, pop, din, dout, count, empty, full;
  - same clk/reset.
- The sequence table is an inferred register array inside packet_collector.

## Test plan
- Single packet, sender 6'b000_001, id 0, data 9'h1A5. Required response:
  - GntUpStr high exactly one cycle, one cycle after the request;
  - PktOut=26'h00003A5 with PktValid high;
  - RxCount=1, SeqErr=0.
- PktReady=0, back-to-back requests, DEPTH=4:
  - four grants, then UpStrFull=1 and the fifth request stays ungranted;
  - raise PktReady for one cycle: UpStrFull falls and the fifth packet is granted.
- Sender 3 sends ids 0, 1, 3, 4. Required response:
  - one SeqErr pulse on id 3, ErrSender=3, ErrCount=1;
  - id 4 raises no error.
- Ids 1022, 1023, 0 from one sender: no SeqErr (wrap). Interleaved senders 1 and 2, each in order: no errors.
- Reset asserted while GntUpStr=1 with 3 packets buffered:
  - all outputs go to reset values immediately;
  - first packet after release, id 0, raises no error.
- CNT_W=2, five packets: RxCount saturates at 3.

Source files
------------

// File: rtl/noc_collector_pkg.sv
// noc_collector_pkg: shared handshake state encoding and packet field layout for the packet collector.
package noc_collector_pkg;
   typedef enum logic {WAIT_REQ = 1'b0, RECEIVE_DATA = 1'b1} state_t;
   localparam int DEF_DATA_W  = 9;
   localparam int DEF_SRC_W   = 6;
   localparam int DEF_ID_W    = 10;
   localparam int DEF_SRC_LSB = DEF_DATA_W;
   localparam int DEF_ID_LSB  = DEF_DATA_W + DEF_SRC_W;
   localparam int DEF_FIELD_W = DEF_ID_LSB + DEF_ID_W;
   function automatic int idLsb(input int dataW, input int srcW);
      return dataW + srcW;
   endfunction
endpackage

// File: rtl/collector_fifo.sv
// collector_fifo: synchronous show-ahead FIFO; the head entry is always visible on dout.
module collector_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rdPtr, wrPtr;
   assign dout  = mem[rdPtr];
   assign empty = count == '0;
   assign full  = count == CW'(DEPTH);
   always_ff @(posedge clk)
      if (push) mem[wrPtr] <= din;
   // DEPTH is a power of two, so the pointers wrap by plain overflow
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop) rdPtr <= rdPtr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/packet_collector.sv
// packet_collector: router local-port sink with FIFO buffering, per-sender PacketID
// sequence checking and saturating receive/error counters.
module packet_collector
   import noc_collector_pkg::*;
#(
   parameter logic [5:0] ROUTER_ID = 6'b001_010,
   parameter int PACKET_W  = DEF_FIELD_W + 1,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int SRC_W     = DEF_SRC_W,
   parameter int ID_W      = DEF_ID_W,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 16,
   parameter int SEQ_CHECK = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PACKET_W-1:0] PacketIn,
   input  logic                ReqUpStr,
   output logic                UpStrFull,
   output logic                GntUpStr,
   output logic [PACKET_W-1:0] PktOut,
   output logic                PktValid,
   input  logic                PktReady,
   output logic [CNT_W-1:0]    RxCount,
   output logic [CNT_W-1:0]    ErrCount,
   output logic                SeqErr,
   output logic [SRC_W-1:0]    ErrSender
);
   localparam int SRC_LSB = DATA_W;
   localparam int ID_LSB  = idLsb(DATA_W, SRC_W);
   localparam int CW      = $clog2(DEPTH) + 1;
   if (PACKET_W < ID_LSB + ID_W || DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0
       || $bits(ROUTER_ID) != 6) begin : gBadParams
      $error("packet_collector: illegal parameter set");
   end
   state_t state;
   logic [ID_W-1:0] expTab [2**SRC_W];
   logic [CW-1:0] count, nextCount;
   logic empty, full, capture, pop, mismatch;
   logic [SRC_W-1:0] src;
   logic [ID_W-1:0] pid;
   assign src       = PacketIn[SRC_LSB +: SRC_W];
   assign pid       = PacketIn[ID_LSB +: ID_W];
   assign capture   = state == WAIT_REQ && ReqUpStr && !full;
   assign PktValid  = !empty;
   assign pop       = PktValid && PktReady;
   assign nextCount = count + CW'(capture) - CW'(pop);
   assign mismatch  = SEQ_CHECK != 0 && pid != expTab[src];
   collector_fifo #(.WIDTH(PACKET_W), .DEPTH(DEPTH)) uFifo (
      .clk(clk), .reset(reset), .push(capture), .pop(pop), .din(PacketIn),
      .dout(PktOut), .count(count), .empty(empty), .full(full)
   );
   // RECEIVE_DATA always returns to WAIT_REQ, so the next state is just "captured this edge"
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= WAIT_REQ;
         GntUpStr  <= 1'b0;
         UpStrFull <= 1'b0;
         SeqErr    <= 1'b0;
         RxCount   <= '0;
         ErrCount  <= '0;
         ErrSender <= '0;
         for (int i = 0; i < 2**SRC_W; i++) expTab[i] <= '0;
      end else begin
         state     <= capture ? RECEIVE_DATA : WAIT_REQ;
         GntUpStr  <= capture;
         UpStrFull <= nextCount == CW'(DEPTH);
         SeqErr    <= capture && mismatch;
         if (capture) begin
            expTab[src] <= pid + 1'b1;
            if (!(&RxCount)) RxCount <= RxCount + 1'b1;
            if (mismatch) begin
               ErrSender <= src;
               if (!(&ErrCount)) ErrCount <= ErrCount + 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_packet_collector.sv
// tb_packet_collector: directed and randomized checks of packet_collector against a
// queue-based reference model; a second instance with 2-bit counters checks saturation.
module tb_packet_collector;
   localparam int PW = 26, DW = 9, SW = 6, IW = 10, DEPTH = 4;
   logic clk = 1'b0, reset = 1'b0;
   logic [PW-1:0] PacketIn = '0;
   logic ReqUpStr = 1'b0, PktReady = 1'b0;
   logic UpStrFull, GntUpStr, PktValid, SeqErr;
   logic [PW-1:0] PktOut;
   logic [15:0] RxCount, ErrCount;
   logic [SW-1:0] ErrSender;
   logic UpStrFull2, GntUpStr2, PktValid2, SeqErr2;
   logic [PW-1:0] PktOut2;
   logic [1:0] RxCount2, ErrCount2;
   logic [SW-1:0] ErrSender2;

   packet_collector dut (
      .clk(clk), .reset(reset), .PacketIn(PacketIn), .ReqUpStr(ReqUpStr),
      .UpStrFull(UpStrFull), .GntUpStr(GntUpStr), .PktOut(PktOut), .PktValid(PktValid),
      .PktReady(PktReady), .RxCount(RxCount), .ErrCount(ErrCount), .SeqErr(SeqErr),
      .ErrSender(ErrSender)
   );
   packet_collector #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .PacketIn(PacketIn), .ReqUpStr(ReqUpStr),
      .UpStrFull(UpStrFull2), .GntUpStr(GntUpStr2), .PktOut(PktOut2), .PktValid(PktValid2),
      .PktReady(PktReady), .RxCount(RxCount2), .ErrCount(ErrCount2), .SeqErr(SeqErr2),
      .ErrSender(ErrSender2)
   );

   always #5 clk = ~clk;

   logic [PW-1:0] mq[$];
   int mTab[64];
   bit mBusy, mGnt, mSeqErr;
   int mRx, mErr, mErrSender;
   int tests = 0, failed = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] mk(input int s, input int id, input int data);
      logic [PW-1:0] p;
      p = '0;
      p[DW-1:0] = DW'(data);
      p[DW +: SW] = SW'(s);
      p[DW+SW +: IW] = IW'(id);
      p[PW-1] = 1'($urandom);
      return p;
   endfunction

   task automatic modelReset();
      mq.delete();
      foreach (mTab[i]) mTab[i] = 0;
      mBusy = 0; mGnt = 0; mSeqErr = 0;
      mRx = 0; mErr = 0; mErrSender = 0;
   endtask

   task automatic checkAll();
      chk("gnt", GntUpStr, mGnt);
      chk("valid", PktValid, mq.size() > 0);
      chk("full", UpStrFull, mq.size() == DEPTH);
      chk("rxcount", RxCount, mRx);
      chk("rxcount_sat", RxCount2, mRx > 3 ? 3 : mRx);
      chk("seqerr", SeqErr, mSeqErr);
      chk("errcount", ErrCount, mErr);
      chk("errsender", ErrSender, mErrSender);
      if (mq.size() > 0) chk("pktout", PktOut, mq[0]);
   endtask

   // one clock of the reference model: decide acceptance from the spec rules, then compare
   task automatic tick();
      bit acc, pp;
      int s, p;
      acc = ReqUpStr && !mBusy && mq.size() < DEPTH;
      pp = mq.size() > 0 && PktReady;
      s = int'(PacketIn[DW +: SW]);
      p = int'(PacketIn[DW+SW +: IW]);
      mSeqErr = acc && p != mTab[s];
      if (mSeqErr) begin mErr++; mErrSender = s; end
      if (acc) begin mTab[s] = (p + 1) % 1024; mRx++; end
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(PacketIn);
      mBusy = acc;
      mGnt = acc;
      @(posedge clk);
      #1;
      checkAll();
   endtask

   task automatic sendPkt(input logic [PW-1:0] pkt, output int lat);
      PacketIn = pkt;
      ReqUpStr = 1'b1;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         lat++;
         if (GntUpStr) break;
      end
      chk("grant_seen", GntUpStr, 1);
      ReqUpStr = 1'b0;
      tick();
   endtask

   initial begin
      int lat, s, id;
      modelReset();
      #1;
      checkAll();
      @(negedge clk) reset = 1'b1;

      // single packet
      sendPkt(26'h00003A5, lat);
      chk("single_latency", lat, 1);
      chk("single_pktout", PktOut, 26'h00003A5);
      chk("single_valid", PktValid, 1);
      PktReady = 1'b1;
      repeat (2) tick();
      PktReady = 1'b0;

      // fill to DEPTH, fifth request waits for a pop
      for (int i = 0; i < 4; i++) sendPkt(mk(4, i, $urandom), lat);
      chk("full_after_four", UpStrFull, 1);
      PacketIn = mk(4, 4, $urandom);
      ReqUpStr = 1'b1;
      repeat (3) tick();
      chk("fifth_held", GntUpStr, 0);
      PktReady = 1'b1;
      tick();
      PktReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (GntUpStr) break;
      end
      chk("fifth_granted", GntUpStr, 1);
      ReqUpStr = 1'b0;
      tick();
      PktReady = 1'b1;
      repeat (6) tick();

      // sequence errors, wrap and interleaving with PE draining
      sendPkt(mk(3, 0, $urandom), lat);
      sendPkt(mk(3, 1, $urandom), lat);
      sendPkt(mk(3, 3, $urandom), lat);
      chk("gap_errsender", ErrSender, 3);
      chk("gap_errcount", ErrCount, 1);
      sendPkt(mk(3, 4, $urandom), lat);
      chk("resync_errcount", ErrCount, 1);
      sendPkt(mk(7, 1021, $urandom), lat);
      sendPkt(mk(7, 1022, $urandom), lat);
      sendPkt(mk(7, 1023, $urandom), lat);
      sendPkt(mk(7, 0, $urandom), lat);
      chk("wrap_errcount", ErrCount, 2);
      sendPkt(mk(1, 1, $urandom), lat);
      sendPkt(mk(2, 0, $urandom), lat);
      sendPkt(mk(1, 2, $urandom), lat);
      sendPkt(mk(2, 1, $urandom), lat);
      chk("interleave_errcount", ErrCount, 2);
      repeat (3) tick();

      // asynchronous reset mid-handshake with packets buffered
      PktReady = 1'b0;
      for (int i = 0; i < 3; i++) sendPkt(mk(8, i, $urandom), lat);
      PacketIn = mk(8, 3, $urandom);
      ReqUpStr = 1'b1;
      tick();
      chk("pre_reset_gnt", GntUpStr, 1);
      #2 reset = 1'b0;
      #1;
      modelReset();
      ReqUpStr = 1'b0;
      checkAll();
      @(negedge clk) reset = 1'b1;
      sendPkt(mk(8, 0, $urandom), lat);
      chk("post_reset_errcount", ErrCount, 0);
      chk("post_reset_rx", RxCount, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         PktReady = 1'($urandom);
         ReqUpStr = ($urandom % 3) != 0;
         s = $urandom_range(0, 3);
         id = ($urandom % 4 == 0) ? int'($urandom % 1024) : mTab[s];
         PacketIn = mk(s, id, $urandom);
         tick();
      end
      ReqUpStr = 1'b0;
      PktReady = 1'b1;
      repeat (6) tick();
      chk("final_rx_saturated", RxCount2, 3);
      chk("final_drained", PktValid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
